// File: rtl/uart_tx_if.sv
// Valid/ready word handshake between the upstream data register and the UART transmitter.
interface uart_tx_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_tx.sv
// Asynchronous serial transmitter: start bit, LSB-first data, optional even parity, stop bits.
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic     clk_i,
  input  logic     reset_i,
  uart_tx_if.slave up,
  output logic     tx_o,
  output logic     busy_o
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CYC_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state;
  logic [CW-1:0]        cyc_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_q;
  logic                 parity_q;
  logic                 bit_done;
  logic                 ready_c;
  logic                 xfer;

  // Ready also opens in the last cycle of the final stop bit so frames can abut.
  always_comb begin
    bit_done = (cyc_cnt == CYC_LAST);
    ready_c  = !reset_i &&
               ((state == IDLE) || ((state == STOP) && bit_done && (bit_cnt == STOP_LAST)));
    xfer     = up.valid && ready_c;
  end

  assign up.ready = ready_c;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state    <= IDLE;
      cyc_cnt  <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_o     <= 1'b1;
      busy_o   <= 1'b0;
    end else if (xfer) begin
      state    <= START;
      cyc_cnt  <= '0;
      bit_cnt  <= '0;
      shift_q  <= up.data;
      parity_q <= ^up.data;
      tx_o     <= 1'b0;
      busy_o   <= 1'b1;
    end else begin
      if (state != IDLE) begin
        cyc_cnt <= bit_done ? '0 : cyc_cnt + 1'b1;
      end
      case (state)
        START: begin
          if (bit_done) begin
            state   <= DATA;
            bit_cnt <= '0;
            tx_o    <= shift_q[0];
          end
        end
        DATA: begin
          if (bit_done) begin
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                state <= PARITY;
                tx_o  <= parity_q;
              end else begin
                state <= STOP;
                tx_o  <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shift_q <= {1'b0, shift_q[DATA_BITS-1:1]};
              tx_o    <= shift_q[1];
            end
          end
        end
        PARITY: begin
          if (bit_done) begin
            state   <= STOP;
            bit_cnt <= '0;
            tx_o    <= 1'b1;
          end
        end
        STOP: begin
          if (bit_done) begin
            if (bit_cnt == STOP_LAST) begin
              state   <= IDLE;
              bit_cnt <= '0;
              busy_o  <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          tx_o   <= 1'b1;
          busy_o <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Serial transmit stage that takes parallel words from the upstream registered data stage and drives an asynchronous serial line (8N1 by default).
Words arrive on a valid/ready handshake. The block frames each word with a start bit, LSB-first data bits, an optional even-parity bit and stop bits, and holds each bit for a fixed number of clocks.
It is the consumer that sits directly downstream of the pipeline data register and feeds the board TX pin.

Parameters:
CLKS_PER_BIT, 868, clock cycles per serial bit (e.g. 100 MHz / 115200); legal range >= 2
DATA_BITS, 8, data bits per frame; legal range 5..9
PARITY_EN, 0, 1 = append even-parity bit after data bits, 0 = no parity bit
STOP_BITS, 1, number of stop bits; legal values 1 or 2

Ports:
clk_i  input  1  single clock; all state updates on rising edge
reset_i  input  1  synchronous, active-high reset
data_i  input  DATA_BITS  word to transmit; sampled only on handshake
valid_i  input  1  upstream has a word on data_i
ready_o  output  1  block can accept a word this cycle
tx_o  output  1  serial line, idle high; registered output
busy_o  output  1  high while a frame is on the line

Behaviour:
- Clock and reset: one clock (clk_i). Reset is synchronous and active-high (reset_i), sampled only on rising clk_i.
- Reset state and outputs:
  - reset_i high at an edge forces IDLE, clears bit and cycle counters, sets tx_o=1 and busy_o=0.
  - ready_o=0 whenever reset_i is high; ready_o=1 in IDLE otherwise.
- Handshake: a transfer occurs at a rising edge where valid_i && ready_o.
  - data_i is latched into a shift register at that edge.
  - data_i and valid_i are ignored at all other times; changes mid-frame have no effect.
- States: IDLE -> START -> DATA -> (PARITY if PARITY_EN) -> STOP -> IDLE.
  - IDLE: tx_o=1, busy_o=0, ready_o=1. A transfer goes to START.
  - START: tx_o=0 for CLKS_PER_BIT cycles.
  - DATA: DATA_BITS bits, LSB first, each held CLKS_PER_BIT cycles.
  - PARITY: tx_o = XOR of the latched word (even parity), held CLKS_PER_BIT cycles.
  - STOP: tx_o=1 for STOP_BITS*CLKS_PER_BIT cycles.
- Latency: transfer at edge N means tx_o=0 is visible from the cycle after edge N. There is no combinational path from data_i to tx_o.
- Frame length: CLKS_PER_BIT*(1+DATA_BITS+PARITY_EN+STOP_BITS) cycles.
- busy_o is high for exactly the frame length.
- Back-to-back frames:
  - ready_o is also high during the final clock cycle of the last stop bit.
  - A transfer in that cycle goes directly to START; the next start bit follows the stop bit with no idle cycle.
  - If valid_i is low in that cycle, go to IDLE.
- Counters:
  - Cycle counter width is $clog2(CLKS_PER_BIT); it counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary.
  - Bit counter covers DATA_BITS and STOP_BITS. No counter overflows for legal parameters.
- Reset mid-frame: the frame aborts and the latched word is discarded. tx_o=1 from the edge where reset_i is sampled. No partial frame resumes after reset.
- ready_o is combinational from state and counters only, never from valid_i, so there is no valid->ready loop.

Test Plan:
1. CLKS_PER_BIT=4, DATA_BITS=8, PARITY_EN=0, STOP_BITS=1; send 0xA5 -> tx_o is 0 for 4 cycles, then 1,0,1,0,0,1,0,1 (4 cycles each), then 1 for 4 cycles. busy_o is high for 40 cycles. ready_o is low from the cycle after the transfer until the 40th cycle.
2. Same config; valid_i held high with 0x55 then 0xAA -> two frames in 80 consecutive cycles. The second start bit begins on the cycle immediately after the first stop bit.
3. PARITY_EN=1; send 0x07 -> parity bit = 1 (three ones) inserted after bit 7. Frame is 44 cycles. Sending 0x03 gives parity bit 0.
4. Mid-frame, drive valid_i high and toggle data_i to 0xFF -> no acceptance (ready_o=0), and the serialized bits are still 0xA5.
5. Assert reset_i for 1 cycle during data bit 3 -> tx_o=1 on the next cycle, busy_o=0, ready_o=1 after release. A following send of 0x3C produces a clean full frame.
6. STOP_BITS=2 -> tx_o is high for 8 stop cycles. ready_o rises only in the last of those 8 cycles. Frame is 44 cycles.
